// File: rtl/uart_pixel_loader.sv
// rtl/uart_pixel_loader.sv - UART byte-stream parser feeding RGB565 pixels into the frame-buffer write FIFO
// Also owns the SDRAM write address and the power-on clear of all eight pages.
module uart_pixel_loader #(
    parameter int          H_PIX     = 800,
    parameter int          V_PIX     = 480,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_req,
    input  logic        fifo_full,
    input  logic        startup_inc,
    output logic        startup,
    output logic [2:0]  page_set,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic [2:0]  page_show,
    output logic        frame_done,
    output logic        err_overflow
);

    localparam logic [9:0]  LAST_COL = 10'(H_PIX - 1);
    localparam logic [8:0]  LAST_ROW = 9'(V_PIX - 1);
    localparam logic [18:0] LAST_PIX = 19'(H_PIX * V_PIX - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CMD,
        S_HI,
        S_LO
    } state_t;

    state_t      state, next_state;
    logic [7:0]  hi_byte;
    logic [18:0] pix_cnt;

    logic col_last, row_last, clear_last, load_accept, pixel_done, pix_last;

    assign col_last    = (col_add_user == LAST_COL);
    assign row_last    = (row_add_user == LAST_ROW);
    assign clear_last  = (state == S_CLEAR) && (page_set == 3'd7) && row_last && col_last;
    assign load_accept = (state == S_CMD) && rx_valid && (rx_data[7:6] == 2'b01);
    assign pixel_done  = (state == S_LO) && rx_valid;
    assign pix_last    = (pix_cnt == LAST_PIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR: if (startup_inc && clear_last) next_state = S_IDLE;
            S_IDLE:  if (rx_valid && (rx_data == SYNC_BYTE)) next_state = S_CMD;
            S_CMD:   if (rx_valid) next_state = (rx_data[7:6] == 2'b01) ? S_HI : S_IDLE;
            S_HI:    if (rx_valid) next_state = S_LO;
            S_LO:    if (rx_valid) next_state = pix_last ? S_IDLE : S_HI;
            default: next_state = S_CLEAR;
        endcase
    end

    // Address counter; LOAD acceptance overrides a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup      <= 1'b0;
            page_set     <= 3'd0;
            row_add_user <= 9'd0;
            col_add_user <= 10'd0;
        end else if (startup_inc && clear_last) begin
            startup      <= 1'b1;
            page_set     <= 3'd0;
            row_add_user <= 9'd0;
            col_add_user <= 10'd0;
        end else if (load_accept) begin
            page_set     <= rx_data[2:0];
            row_add_user <= 9'd0;
            col_add_user <= 10'd0;
        end else if (startup_inc) begin
            if (col_last) begin
                col_add_user <= 10'd0;
                if (row_last) begin
                    row_add_user <= 9'd0;
                    if (state == S_CLEAR) page_set <= page_set + 3'd1;
                end else begin
                    row_add_user <= row_add_user + 9'd1;
                end
            end else begin
                col_add_user <= col_add_user + 10'd1;
            end
        end
    end

    // Pixel assembly; a dropped pixel still advances the count to keep frame alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_din     <= 16'd0;
            fifo_wr_req  <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            page_show    <= 3'd0;
            hi_byte      <= 8'd0;
            pix_cnt      <= 19'd0;
        end else begin
            fifo_wr_req <= 1'b0;
            frame_done  <= 1'b0;
            if ((state == S_CMD) && rx_valid && (rx_data[7:6] == 2'b00)) begin
                page_show <= rx_data[2:0];
            end
            if (load_accept) begin
                pix_cnt <= 19'd0;
            end
            if ((state == S_HI) && rx_valid) begin
                hi_byte <= rx_data;
            end
            if (pixel_done) begin
                fifo_din <= {hi_byte, rx_data};
                if (fifo_full) begin
                    err_overflow <= 1'b1;
                end else begin
                    fifo_wr_req <= 1'b1;
                end
                if (pix_last) begin
                    frame_done <= 1'b1;
                    pix_cnt    <= 19'd0;
                end else begin
                    pix_cnt <= pix_cnt + 19'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb/tb_uart_pixel_loader.sv - scoreboard bench for uart_pixel_loader on a reduced 8x4 page
module tb_uart_pixel_loader;

    localparam int H = 8;
    localparam int V = 4;
    localparam int PAGE = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [15:0] fifo_din;
    logic        fifo_wr_req;
    logic        fifo_full = 1'b0;
    logic        startup_inc = 1'b0;
    logic        startup;
    logic [2:0]  page_set;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    logic [2:0]  page_show;
    logic        frame_done;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [15:0] exp_q[$];

    uart_pixel_loader #(.H_PIX(H), .V_PIX(V), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .fifo_din(fifo_din), .fifo_wr_req(fifo_wr_req), .fifo_full(fifo_full),
        .startup_inc(startup_inc), .startup(startup), .page_set(page_set),
        .row_add_user(row_add_user), .col_add_user(col_add_user),
        .page_show(page_show), .frame_done(frame_done), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every FIFO strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (!rst && fifo_wr_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write unexpected: got %h, required no write", fifo_din);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (fifo_din !== e) begin
                    errors++;
                    $display("FAIL fifo_din: got %h, required %h", fifo_din, e);
                end
            end
        end
        if (!rst && frame_done) frames++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic full);
        rx_data  = b;
        rx_valid = 1'b1;
        fifo_full = full;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        fifo_full = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_pixel(input logic [15:0] p, input logic full);
        if (!full) exp_q.push_back(p);
        send_byte(p[15:8], 1'b0);
        send_byte(p[7:0], full);
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            startup_inc = 1'b1;
            @(posedge clk); #1;
        end
        startup_inc = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_startup"}, startup, 0);
        check({tag, "_wr_req"}, fifo_wr_req, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err"}, err_overflow, 0);
        check({tag, "_din"}, fifo_din, 0);
        check({tag, "_addr"}, {page_set, row_add_user, col_add_user}, 0);
        check({tag, "_show"}, page_show, 0);
    endtask

    initial begin
        int f0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Clear phase: host bytes are ignored, pages step at each boundary.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("clear_ignores_load", page_set, 0);
        pulse_inc(3);
        check("clear_col", col_add_user, 3);
        pulse_inc(PAGE - 3);
        check("clear_page1", page_set, 1);
        for (int p = 1; p < 7; p++) begin
            pulse_inc(PAGE);
            check("clear_page_step", page_set, p + 1);
            check("clear_startup_low", startup, 0);
        end
        pulse_inc(PAGE - 1);
        check("clear_before_last", startup, 0);
        pulse_inc(1);
        check("clear_startup", startup, 1);
        check("clear_addr_zero", {page_set, row_add_user, col_add_user}, 0);

        // SHOW
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        check("show_page", page_show, 5);
        check("show_page_set", page_set, 0);

        // LOAD page 2 with two pixels
        send_byte(8'hA5, 1'b0);
        send_byte(8'h42, 1'b0);
        check("load_page_set", page_set, 2);
        send_pixel(16'h1234, 1'b0);
        send_pixel(16'hABCD, 1'b0);

        // Address wrap outside CLEAR
        pulse_inc(H);
        check("wrap_col", col_add_user, 0);
        check("wrap_row", row_add_user, 1);
        pulse_inc((V - 2) * H + H - 1);
        check("corner", {row_add_user, col_add_user}, {9'(V - 1), 10'(H - 1)});
        pulse_inc(1);
        check("corner_wrap", {page_set, row_add_user, col_add_user}, {3'd2, 19'd0});

        // Finish the partial frame
        for (int i = 2; i < PAGE; i++) send_pixel(16'(i * 16'h0111), 1'b0);
        check("partial_frame_done", frames, 1);

        // Full frame: frame_done only after the final LO byte
        send_byte(8'hA5, 1'b0);
        send_byte(8'h43, 1'b0);
        for (int i = 0; i < PAGE - 1; i++) send_pixel(16'hF000 ^ 16'(i * 16'h0203), 1'b0);
        exp_q.push_back(16'h5A3C);
        send_byte(8'h5A, 1'b0);
        check("no_early_done", frames, 1);
        send_byte(8'h3C, 1'b0);
        check("full_frame_done", frames, 2);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("idle_after_frame", frames, 2);

        // Overflow on one pixel; frame still completes on count
        send_byte(8'hA5, 1'b0);
        send_byte(8'h44, 1'b0);
        check("ovf_page", page_set, 4);
        check("ovf_err_before", err_overflow, 0);
        f0 = frames;
        for (int i = 0; i < PAGE; i++) send_pixel(16'(16'h0800 + i), i == 5);
        check("ovf_err", err_overflow, 1);
        check("ovf_frame_done", frames, f0 + 1);
        check("ovf_queue_drained", exp_q.size(), 0);

        // LOAD acceptance beats a coincident startup_inc
        pulse_inc(3);
        check("pre_coinc_col", col_add_user, 3);
        send_byte(8'hA5, 1'b0);
        rx_data = 8'h41; rx_valid = 1'b1; startup_inc = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; startup_inc = 1'b0;
        @(posedge clk); #1;
        check("coinc_addr", {page_set, row_add_user, col_add_user}, {3'd1, 19'd0});
        check("err_sticky", err_overflow, 1);

        // Reset mid-frame
        send_byte(8'h12, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        check("midrst_clear_ignores", page_show, 0);
        pulse_inc(PAGE);
        check("midrst_clear_restart", page_set, 1);
        check("midrst_startup", startup, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
# uart_pixel_loader

- Producer side of the TFT frame-buffer path. It parses a byte stream from the UART receiver into show/load commands and RGB565 pixels, and pushes pixels into the write FIFO.
- It generates the SDRAM write address (`page_set`, `row_add_user`, `col_add_user`), advancing it on each write-completion pulse from the TFT/SDRAM controller.
- After reset it first sequences a full clear of all eight pages with `startup` low, then raises `startup` and accepts host traffic.

## Interface

Parameters:
- `H_PIX`, 800: pixels per row.
- `V_PIX`, 480: rows per page.
- `SYNC_BYTE`, 8'hA5: frame header byte.

Ports:
- `clk`  in  1  system clock; same clock as the SDRAM/TFT controller.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `fifo_din`  out  16  RGB565 pixel, {R[4:0], G[5:0], B[4:0]}.
- `fifo_wr_req`  out  1  one-cycle FIFO write strobe.
- `fifo_full`  in  1  FIFO full flag.
- `startup_inc`  in  1  one-cycle pulse; one SDRAM word has been written at the current address.
- `startup`  out  1  0 = clear phase, 1 = normal operation.
- `page_set`  out  3  write page.
- `row_add_user`  out  9  write row, 0..V_PIX-1.
- `col_add_user`  out  10  write column, 0..H_PIX-1.
- `page_show`  out  3  displayed page.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a LOAD.
- `err_overflow`  out  1  sticky; a pixel was dropped on `fifo_full`. Cleared only by reset.

## Operation

- Reset values:
  - `startup`, `fifo_wr_req`, `frame_done`, `err_overflow` = 0.
  - `fifo_din`, `page_set`, `row_add_user`, `col_add_user`, `page_show` = 0.
  - State = CLEAR.
- Address counter (active in every state):
  - On `startup_inc`, `col_add_user` increments.
  - At H_PIX-1 the column wraps to 0 and `row_add_user` increments.
  - At V_PIX-1 the row wraps to 0. In CLEAR only, `page_set` also increments on this wrap.
  - Outside CLEAR, the row wrap leaves `page_set` unchanged.
- CLEAR:
  - `rx_valid` is ignored.
  - On the `startup_inc` that completes page 7, row V_PIX-1, column H_PIX-1, the block moves to IDLE.
  - In the same cycle, `startup` is set to 1 and `page_set`, row and column are set to 0.
- IDLE:
  - A byte equal to SYNC_BYTE moves the block to CMD.
  - Any other byte is discarded.
- CMD: decodes the next byte by `rx_data[7:6]`.
  - 2'b00 (SHOW): `page_show` <= `rx_data[2:0]`; go to IDLE.
  - 2'b01 (LOAD): `page_set` <= `rx_data[2:0]`; row, column and the pixel counter are cleared; go to HI.
  - Any other value: go to IDLE; no output changes.
- HI: the byte is latched as the pixel MSB; go to LO.
- LO:
  - The byte completes the pixel: `fifo_din` <= {hi, lo}.
  - If `fifo_full` = 0, `fifo_wr_req` pulses.
  - If `fifo_full` = 1, there is no strobe and `err_overflow` <= 1.
  - In both cases the pixel counter (19 bits, 0..H_PIX*V_PIX-1) increments. Counting the dropped pixel keeps frame alignment.
  - If the pixel just completed is number H_PIX*V_PIX-1: `frame_done` pulses, the counter is cleared, and the block goes to IDLE.
  - Otherwise the block returns to HI.
- No timeout is implemented. A short frame leaves the block in HI/LO until the host sends the remaining bytes or reset is asserted.

## Timing

- All outputs are registered.
- `fifo_wr_req`, `fifo_din` and `frame_done` update in the cycle after the `rx_valid` of the LO byte.
- `fifo_wr_req` is never high in two consecutive cycles, because bytes are at least one UART character apart.
- Address outputs change in the cycle after `startup_inc`.
- `startup` rises in the cycle after the final clear `startup_inc`.
- SHOW takes effect on `page_show` in the cycle after the command byte.
- If `startup_inc` and LOAD acceptance fall in the same cycle, LOAD wins: the counters clear to 0 and the increment is lost.
- If `rx_valid` and `startup_inc` coincide, both take effect; parsing and address counting are independent.
- Asserting `rst` at any point, including mid-CLEAR or mid-frame, returns every output to its reset value immediately. CLEAR then restarts from page 0.

## Test plan

- **Clear phase:** reset, then pulse `startup_inc` 8*384000 times, with `rx_valid` bytes sent during the clear.
  - Each page boundary steps `page_set`.
  - After the last pulse: `startup` = 1 and all addresses = 0.
  - No FIFO writes occur during the clear.
- **SHOW:** after the clear, send A5, 05 → `page_show` = 5; `page_set` unchanged; no FIFO writes.
- **LOAD:** send A5, 42, then 12, 34, AB, CD.
  - `page_set` = 2.
  - Two `fifo_wr_req` pulses with `fifo_din` = 16'h1234, then 16'hABCD.
- **Address wrap:** pulse `startup_inc` 800 times after LOAD → col = 0, row = 1. At row 479, col 799, one pulse → row = 0, col = 0, `page_set` unchanged.
- **Full frame:** stream 384000 pixels → exactly one `frame_done` pulse, after the final LO byte; the next byte F0 is ignored (IDLE).
- **Overflow:** hold `fifo_full` = 1 during one LO byte → no strobe for that pixel; `err_overflow` = 1 and stays set; the frame still completes after 384000 pixels.
- **Reset mid-frame:** assert `rst` during a LOAD → all outputs 0, `startup` = 0, CLEAR restarts.
